stream_demux: RTL
=================

// Module: stream_demux
// PURPOSE
//  1-to-N valid/ready stream demultiplexer; the distributing counterpart of the mux-based selectors.
//  Steers each upstream word to the downstream lane picked by up_sel, through one registered holding slot per lane.
//  Sits between a single producer and N independent consumers.
//  A stalled lane blocks only words addressed to that lane.
// PARAMETERS
//  N      4   number of downstream lanes, 2..16
//  W      8   data width in bits
//  SEL_W  $clog2(N)   select width (derived localparam, not overridable)
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  up_valid    in   1       upstream word present
//  up_data     in   W       upstream word
//  up_sel      in   SEL_W   destination lane index
//  up_ready    out  1       upstream word accepted this cycle when up_valid && up_ready
//  down_valid  out  N       per-lane word present
//  down_data   out  N*W     per-lane word; lane i occupies bits [i*W +: W]
//  down_ready  in   N       per-lane consumer ready
//  sel_err     out  1       1-cycle pulse: word with up_sel >= N was accepted and dropped
// BEHAVIOUR
//  Reset: all lane slots empty; down_valid = 0; down_data = 0; sel_err = 0; round-robin pointer = 0.
//  Lane slot i: full flag plus W-bit data register.
//  Transfers:
//   - Downstream: down_valid[i] && down_ready[i] empties slot i at the clock edge.
//   - Upstream: accepted word is written into slot up_sel; down_valid[up_sel] rises the next cycle.
//   - Latency: exactly 1 cycle from acceptance to down_valid.
//  Ready: up_ready = !full[up_sel] || down_ready[up_sel], combinational from up_sel and down_ready.
//   - Full throughput per lane: same-cycle drain and refill of one slot is legal; data is replaced, down_valid stays 1.
//  up_ready does not depend on up_valid.
//  Holding rule: down_data[i] is stable while down_valid[i] && !down_ready[i]; no slot is ever overwritten while full and not draining.
//  Out-of-range select (N not a power of 2, up_sel >= N):
//   - up_ready = 1, the word is discarded, sel_err pulses the next cycle.
//   - No slot changes.
//  Simultaneous events: drains on any lanes and one fill happen in the same cycle independently.
//  Reset mid-operation: rst wins over every transfer; held words are lost; up_ready is forced to 0 while rst = 1.
//  down_data of an empty slot keeps its last value and carries no meaning.
// CONFIGURATION
//  STREAM_DEMUX_RR_EN defined: up_sel is ignored.
//   - Destination is an internal round-robin pointer rr, values 0..N-1.
//   - rr advances by 1, wrapping N-1 -> 0, on each accepted word only.
//   - up_ready = !full[rr] || down_ready[rr].
//   - sel_err is tied to 0.
//  STREAM_DEMUX_RR_EN undefined: explicit up_sel steering as above; no rr register exists.
// STRUCTURE
//  Package stream_demux_pkg: DEFAULT_N, DEFAULT_W, MAX_N = 16 constants.
//  Sub-module stream_demux_slot: one full flag and data register with wr_en, rd_en, full and data ports.
//   - Instantiated N times in a generate loop.
//  Top module holds the select decode, up_ready mux, rr pointer and sel_err register.
// TESTING
//  1. Reset, then up_sel=2, data 0xA5, valid 1 cycle, all down_ready=1
//     -> down_valid=4'b0100 next cycle with lane2 data 0xA5, then 0.
//  2. Lane1 down_ready=0, send 0x11 then 0x22 to lane1
//     -> first accepted; up_ready=0 on second; lane1 holds 0x11 stable.
//     -> Raise down_ready: 0x22 accepted the same cycle 0x11 drains.
//  3. Lane0 stalled and full, send 0x33 to lane3
//     -> accepted; down_valid[3]=1 next cycle; lane0 unchanged.
//  4. N=3, up_sel=3, data 0x7E -> up_ready=1, sel_err=1 next cycle, down_valid stays 0.
//  5. Assert rst with lanes 0 and 2 full -> down_valid=0 next cycle; up_ready=0 during rst.
//  6. STREAM_DEMUX_RR_EN, N=4, 6 back-to-back words 0..5, all down_ready=1
//     -> lanes 0,1,2,3,0,1 in order, one word per cycle.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults and limits for the stream demultiplexer
package stream_demux_pkg;
  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;
  localparam int MAX_N = 16;
endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one-word holding slot (full flag + data) for a single downstream lane
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic [W-1:0] data
);
  logic         full_d, full_q;
  logic [W-1:0] data_d, data_q;
  always_comb begin
    full_d = wr_en ? 1'b1 : rd_en ? 1'b0 : full_q;
    data_d = wr_en ? wr_data : data_q;
  end
  always_ff @(posedge clk) begin
    full_q <= rst ? 1'b0 : full_d;
    data_q <= rst ? '0 : data_d;
  end
  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N valid/ready demux, one registered slot per lane; STREAM_DEMUX_RR_EN selects round-robin steering
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [W-1:0]     up_data,
  input  logic [SEL_W-1:0] up_sel,
  output logic             up_ready,
  output logic [N-1:0]     down_valid,
  output logic [N*W-1:0]   down_data,
  input  logic [N-1:0]     down_ready,
  output logic             sel_err
);
  logic [SEL_W-1:0] dest;
  logic             in_range, busy, acc;
  logic [N-1:0]     full, wr_en, rd_en;
`ifdef STREAM_DEMUX_RR_EN
  logic [SEL_W-1:0] rr_d, rr_q;
  logic             unused_sel;
  assign unused_sel = ^up_sel;
  assign dest = rr_q;
  assign sel_err = 1'b0;
  always_comb rr_d = acc ? (rr_q == SEL_W'(N - 1) ? '0 : rr_q + 1'b1) : rr_q;
  always_ff @(posedge clk) rr_q <= rst ? '0 : rr_d;
`else
  logic sel_err_d, sel_err_q;
  assign dest = up_sel;
  assign sel_err = sel_err_q;
  always_comb sel_err_d = acc && !in_range;
  always_ff @(posedge clk) sel_err_q <= rst ? 1'b0 : sel_err_d;
`endif
  assign in_range = 32'(dest) < N;
  always_comb begin
    busy = 1'b0;
    wr_en = '0;
    for (int i = 0; i < N; i++) begin
      busy = busy | (dest == SEL_W'(i) && full[i] && !down_ready[i]);
      wr_en[i] = acc && in_range && dest == SEL_W'(i);
    end
  end
  assign up_ready = !rst && !busy;
  assign acc = up_valid && up_ready;
  assign rd_en = full & down_ready;
  assign down_valid = full;
  for (genvar g = 0; g < N; g++) begin : g_lane
    stream_demux_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .rd_en   (rd_en[g]),
      .wr_data (up_data),
      .full    (full[g]),
      .data    (down_data[g*W +: W])
    );
  end
endmodule
